// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encodings, default width and counter sizing for serial_adder.
package serial_adder_pkg;
    localparam int SA_N_DEFAULT = 8;
    typedef enum logic [1:0] {
        SA_IDLE = 2'd0,
        SA_RUN  = 2'd1,
        SA_DONE = 2'd2
    } sa_state_t;
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/serial_adder_fa_v1.sv
// fa_v1: 1-bit full adder cell.
module fa_v1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, one fa_v1 cell, LSB first, N cycles per add.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = SA_N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = cnt_width(N);
    sa_state_t state, next;
    logic [N-1:0] op_a, op_b, res, res_next;
    logic [N:0] res_ext;
    logic [CW-1:0] cnt;
    logic carry, fa_s, fa_c, last, load, run;

    fa_v1 u_fa (
        .a (op_a[0]),
        .b (op_b[0]),
        .ci(carry),
        .s (fa_s),
        .co(fa_c)
    );

    assign run      = state == SA_RUN;
    assign last     = cnt == CW'(N - 1);
    assign load     = start && !run;
    assign res_ext  = {fa_s, res};
    // dropping the LSB of {sum_bit, res} works for N=1 as well as wider results
    assign res_next = res_ext[N:1];

    always_ff @(posedge clk) begin
        if (reset) state <= SA_IDLE;
        else state <= next;
    end

    always_comb begin
        next = run ? (last ? SA_DONE : SA_RUN) : (start ? SA_RUN : SA_IDLE);
    end

    always_comb begin
        busy = run;
        done = state == SA_DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (load) begin
            op_a  <= a;
            op_b  <= b;
            carry <= c_in;
            cnt   <= '0;
        end else if (run) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= fa_c;
            res   <= res_next;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum   <= res_next;
                c_out <= fa_c;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // on the last bit, carry holds the carry into the MSB
    always_ff @(posedge clk) begin
        if (reset) ovf <= 1'b0;
        else if (run && last) ovf <= carry ^ fa_c;
    end
`endif
endmodule
